pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage core. Drives the PC write enable and the IF/ID register controls (stall, flush, write), inserts ID/EX bubbles, freezes the back end during multi-cycle data-memory accesses, and drains the pipe on halt. It sits beside the hazard-detection inputs from ID/EX and EX/MEM. It exists so that the IF/ID register, which gives stall priority over flush, never receives conflicting commands.

## Interface
- MEM_TIMEOUT, 255: data-memory wait cycles before the block enters ERROR (1..255).
- Clock_i  in  1  system clock; all state updates on the rising edge.
- Reset_n_i  in  1  asynchronous, active-low reset.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_RegRt_i  in  5  destination register of that load.
- IFID_RegRs_i, IFID_RegRt_i  in  5 each  source registers of the instruction in ID.
- IFID_UsesRt_i  in  1  the instruction in ID reads rt.
- Branch_taken_i  in  1  branch resolved taken in ID.
- Jump_i  in  1  jump in ID.
- IMem_ready_i  in  1  instruction word valid this cycle.
- EXMEM_MemAccess_i  in  1  load/store in MEM stage.
- DMem_ack_i  in  1  data memory completes the access this cycle.
- Halt_i  in  1  halt instruction decoded in ID.
- PCWrite_o  out  1  PC register enable.
- IFID_Stall_o  out  1  hold IF/ID.
- IFID_Flush_o  out  1  zero IF/ID.
- IFID_Write_o  out  1  IF/ID load enable; always equals ~IFID_Stall_o outside reset.
- IDEX_Bubble_o  out  1  zero ID/EX control fields.
- Pipe_Hold_o  out  1  hold ID/EX, EX/MEM, MEM/WB.
- DMem_req_o  out  1  data-memory request.
- State_o  out  2  FSM state: RUN=0, DWAIT=1, HALT=2, ERROR=3.
- Halted_o, Error_o  out  1 each  state is HALT / ERROR.
- StallCount_o, FlushCount_o  out  16 each  saturating performance counters.

## Operation
- The FSM state is registered. All control outputs are combinational from the state and the inputs. IFID_Stall_o and IFID_Flush_o are never both 1.
- Freeze means PCWrite_o=0, IFID_Stall_o=1, Pipe_Hold_o=1, IDEX_Bubble_o=0, IFID_Flush_o=0.
- Hazard is: IDEX_MemRead_i & IDEX_RegRt_i!=0 & (IDEX_RegRt_i==IFID_RegRs_i | (IFID_UsesRt_i & IDEX_RegRt_i==IFID_RegRt_i)).
- RUN priority, highest first:
  1. EXMEM_MemAccess_i & !DMem_ack_i: freeze, then go to DWAIT. The wait counter clears to 0.
  2. Hazard: PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1. The branch/jump flush is suppressed.
  3. Branch_taken_i | Jump_i: PCWrite_o=1, IFID_Flush_o=1.
  4. !IMem_ready_i: PCWrite_o=0, IFID_Flush_o=1 (inserts a nop).
  5. Halt_i: normal advance this cycle, then go to HALT.
  6. Otherwise: PCWrite_o=1, IFID_Write_o=1, all other outputs 0.
- DMem_req_o = EXMEM_MemAccess_i in RUN, and 1 in DWAIT.
- DWAIT:
  - Without ack: freeze; the counter increments. If the counter equals MEM_TIMEOUT-1, go to ERROR.
  - Ack cycle: apply RUN priorities 2-6 and go to RUN; on a Halt_i advance (priority 5), go to HALT instead.
- HALT: PCWrite_o=0, IFID_Flush_o=1, Pipe_Hold_o=0, Halted_o=1. The pipe drains nops. Only reset leaves HALT.
- ERROR: freeze, Error_o=1, DMem_req_o=0. Only reset leaves ERROR.
- StallCount_o increments on each RUN/DWAIT cycle with PCWrite_o=0.
- FlushCount_o increments on each RUN/DWAIT cycle with IFID_Flush_o=1.
- Both counters saturate at 0xFFFF.

## Timing
- Reset (asynchronous, immediate) sets:
  - State_o=0 and both counters 0.
  - PCWrite_o, IFID_Stall_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Pipe_Hold_o, DMem_req_o, Halted_o, Error_o all 0.
  - The first rising edge after deassertion runs RUN logic.
- Control outputs have zero-cycle latency from inputs. State and counters change one edge later.
- A load-use hazard costs exactly 1 stall cycle, because the load leaves EX on the next edge.
- A zero-wait access (ack in the same cycle as the request) causes no freeze.
- A DWAIT lasting N cycles before ack gives N frozen cycles. The ack cycle itself advances.
- Timeout: with no ack, ERROR is entered on the edge ending the MEM_TIMEOUT-th DWAIT cycle.
- Reset mid-DWAIT aborts the access: DMem_req_o falls immediately.

## Test plan
- Load r5 in EX, ID reads rs=r5 -> exactly one cycle of PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1; StallCount_o=1.
- Same as above but IDEX_RegRt_i=0 -> no stall.
- Hazard and Branch_taken_i together -> stall only, IFID_Flush_o=0. Branch_taken_i alone on the next cycle -> IFID_Flush_o=1, PCWrite_o=1; FlushCount_o=1.
- MemAccess with ack after 3 cycles -> 3 frozen cycles with State_o=1, DMem_req_o=1 throughout; ack cycle advances; State_o back to 0.
- MEM_TIMEOUT=4, no ack -> Error_o=1 after 4 DWAIT cycles, PCWrite_o held 0. Reset_n_i low mid-ERROR -> all outputs 0 immediately.
- Halt_i -> advance, then HALT with Halted_o=1, IFID_Flush_o=1 every cycle. 70000 stall cycles -> StallCount_o=0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC/IF-ID control, ID/EX bubbles, back-end freeze on slow data memory, halt drain.
// Latency: control outputs are combinational (0 cycles); state and counters update on the next Clock_i edge.
// Backpressure: an un-acked data access freezes the whole pipe; a load-use hazard stalls the front end for one cycle.
//
// Ports:
//   Clock_i, Reset_n_i            clock, asynchronous active-low reset
//   IDEX_* / IFID_*               load-use hazard operands (load in EX, sources of the instruction in ID)
//   Branch_taken_i, Jump_i        control-flow redirect resolved in ID
//   IMem_ready_i                  instruction fetch valid
//   EXMEM_MemAccess_i, DMem_ack_i data-memory handshake for the MEM stage
//   Halt_i                        halt decoded in ID
//   PCWrite_o, IFID_*_o, IDEX_Bubble_o, Pipe_Hold_o, DMem_req_o   pipeline controls
//   State_o, Halted_o, Error_o    FSM status
//   StallCount_o, FlushCount_o    saturating performance counters
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        Clock_i,
    input  logic        Reset_n_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RegRt_i,
    input  logic [4:0]  IFID_RegRs_i,
    input  logic [4:0]  IFID_RegRt_i,
    input  logic        IFID_UsesRt_i,
    input  logic        Branch_taken_i,
    input  logic        Jump_i,
    input  logic        IMem_ready_i,
    input  logic        EXMEM_MemAccess_i,
    input  logic        DMem_ack_i,
    input  logic        Halt_i,
    output logic        PCWrite_o,
    output logic        IFID_Stall_o,
    output logic        IFID_Flush_o,
    output logic        IFID_Write_o,
    output logic        IDEX_Bubble_o,
    output logic        Pipe_Hold_o,
    output logic        DMem_req_o,
    output logic [1:0]  State_o,
    output logic        Halted_o,
    output logic        Error_o,
    output logic [15:0] StallCount_o,
    output logic [15:0] FlushCount_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DWAIT = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    // Last value of the wait counter before giving up on the access.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, flush_cnt_q;

    logic hazard;
    logic issue;        // front-end priorities (hazard..advance) apply this cycle
    logic pc_write, stall, flush, bubble, hold, dmem_req;
    logic count_en;

    assign hazard = IDEX_MemRead_i && (IDEX_RegRt_i != 5'd0) &&
                    ((IDEX_RegRt_i == IFID_RegRs_i) ||
                     (IFID_UsesRt_i && (IDEX_RegRt_i == IFID_RegRt_i)));

    always_comb begin
        pc_write   = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        bubble     = 1'b0;
        hold       = 1'b0;
        dmem_req   = 1'b0;
        issue      = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            ST_RUN: begin
                dmem_req = EXMEM_MemAccess_i;
                if (EXMEM_MemAccess_i && !DMem_ack_i) begin
                    stall      = 1'b1;
                    hold       = 1'b1;
                    state_d    = ST_DWAIT;
                    wait_cnt_d = 8'd0;
                end else begin
                    issue = 1'b1;
                end
            end
            ST_DWAIT: begin
                dmem_req = 1'b1;
                if (!DMem_ack_i) begin
                    stall      = 1'b1;
                    hold       = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    issue   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                flush = 1'b1;
            end
            default: begin
                stall = 1'b1;
                hold  = 1'b1;
            end
        endcase

        // Hazard outranks redirect so IF/ID never sees stall and flush together.
        if (issue) begin
            if (hazard) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end else if (Branch_taken_i || Jump_i) begin
                pc_write = 1'b1;
                flush    = 1'b1;
            end else if (!IMem_ready_i) begin
                flush = 1'b1;
            end else begin
                pc_write = 1'b1;
                if (Halt_i) begin
                    state_d = ST_HALT;
                end
            end
        end
    end

    // Controls are forced low while reset is held, independent of the inputs.
    assign PCWrite_o     = Reset_n_i & pc_write;
    assign IFID_Stall_o  = Reset_n_i & stall;
    assign IFID_Flush_o  = Reset_n_i & flush;
    assign IFID_Write_o  = Reset_n_i & ~stall;
    assign IDEX_Bubble_o = Reset_n_i & bubble;
    assign Pipe_Hold_o   = Reset_n_i & hold;
    assign DMem_req_o    = Reset_n_i & dmem_req;
    assign State_o       = state_q;
    assign Halted_o      = (state_q == ST_HALT);
    assign Error_o       = (state_q == ST_ERROR);
    assign StallCount_o  = stall_cnt_q;
    assign FlushCount_o  = flush_cnt_q;

    assign count_en = (state_q == ST_RUN) || (state_q == ST_DWAIT);

    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (count_en && !pc_write && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (count_en && flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

endmodule
